sched_ws: RTL and testbench

- Phase scheduler for the cpu2 datapath. It replaces the fixed 4-phase sequencer with a version that supports memory wait states, run/halt/single-step control and an instruction-retired counter.
- Generates the fetch/exec/mem/writeback phase levels plus a per-phase completion strobe. The CPU gates all side effects (IC load, PC increment, Ra change, writeback) with that strobe.
- Sits between the clock/reset pins, the CPU core and the memory-bus ready line.

---
 rtl/sched_pkg.sv | 21 ++
 rtl/sched_ws_wait_timer.sv | 39 +++
 rtl/sched_ws.sv | 120 ++++++++++++
 tb/tb_sched_ws.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared encodings for the phase scheduler: state register values and the
// externally visible clk_stat codes used by the CPU top and debug monitor.
package sched_pkg;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_HALT = 3'd0;
  localparam sched_state_t ST_F    = 3'd1;
  localparam sched_state_t ST_E    = 3'd2;
  localparam sched_state_t ST_M    = 3'd3;
  localparam sched_state_t ST_W    = 3'd4;

  localparam logic [2:0] CS_HALT  = 3'd0;
  localparam logic [2:0] CS_F     = 3'd1;
  localparam logic [2:0] CS_E     = 3'd2;
  localparam logic [2:0] CS_M     = 3'd3;
  localparam logic [2:0] CS_W     = 3'd4;
  localparam logic [2:0] CS_FWAIT = 3'd5;
  localparam logic [2:0] CS_MWAIT = 3'd6;

endpackage

// File: rtl/sched_ws_wait_timer.sv
// Saturating wait-state counter; clear has priority over enable, and at_max
// flags the timeout threshold.
module wait_timer #(
  parameter int WAIT_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [WAIT_W-1:0] cnt,
  output logic              at_max
);

  localparam logic [WAIT_W-1:0] MAX_V = WAIT_W'(WAIT_MAX);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == MAX_V);
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_max) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sched_ws.sv
// Phase scheduler: HALT/F/E/M/W sequencing with memory wait states,
// run/halt/single-step control and an instruction-retired counter.
module sched_ws
  import sched_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int WAIT_W    = 4,
  parameter int WAIT_MAX  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic                 mbus_ready,
  input  logic                 mem_req,
  output logic                 phf,
  output logic                 phe,
  output logic                 phm,
  output logic                 phw,
  output logic                 ph_done,
  output logic                 halted,
  output logic                 bus_err,
  output logic [WAIT_W-1:0]    wait_cnt,
  output logic [CNT_WIDTH-1:0] icnt,
  output logic [2:0]           clk_stat
);

  sched_state_t         state_q, state_d;
  logic                 step_mode_q, step_mode_d;
  logic [CNT_WIDTH-1:0] icnt_q, icnt_d;
  logic                 at_max;
  logic                 bus_phase;
  logic                 tmr_en;

  // Only F and a bus-using M sample mbus_ready and can accumulate waits.
  assign bus_phase = (state_q == ST_F) || ((state_q == ST_M) && mem_req);
  assign tmr_en    = bus_phase && !ph_done;
  assign bus_err   = bus_phase && at_max && !mbus_ready;
  assign halted    = (state_q == ST_HALT);
  assign icnt      = icnt_q;

  wait_timer #(
    .WAIT_W   (WAIT_W),
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (!tmr_en),
    .en     (tmr_en),
    .cnt    (wait_cnt),
    .at_max (at_max)
  );

  always_comb begin
    phf      = 1'b0;
    phe      = 1'b0;
    phm      = 1'b0;
    phw      = 1'b0;
    ph_done  = 1'b0;
    clk_stat = CS_HALT;
    case (state_q)
      ST_F: begin
        phf      = 1'b1;
        ph_done  = mbus_ready || at_max;
        clk_stat = (wait_cnt != '0) ? CS_FWAIT : CS_F;
      end
      ST_E: begin
        phe      = 1'b1;
        ph_done  = 1'b1;
        clk_stat = CS_E;
      end
      ST_M: begin
        phm      = 1'b1;
        ph_done  = !mem_req || mbus_ready || at_max;
        clk_stat = (wait_cnt != '0) ? CS_MWAIT : CS_M;
      end
      ST_W: begin
        phw      = 1'b1;
        ph_done  = 1'b1;
        clk_stat = CS_W;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    icnt_d      = icnt_q;
    case (state_q)
      ST_HALT: begin
        if (run || step) begin
          state_d     = ST_F;
          step_mode_d = !run;
        end
      end
      ST_F: if (ph_done) state_d = ST_E;
      ST_E: state_d = ST_M;
      ST_M: if (ph_done) state_d = ST_W;
      ST_W: begin
        icnt_d  = icnt_q + CNT_WIDTH'(1);
        state_d = (run && !step_mode_q) ? ST_F : ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HALT;
      step_mode_q <= 1'b0;
      icnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      icnt_q      <= icnt_d;
    end
  end

endmodule

// File: tb/tb_sched_ws.sv
// Directed bench for sched_ws: stimulus pushes per-cycle expectations into a
// queue, a negedge monitor pops and compares them against the outputs.
module tb_sched_ws;

  logic        clk = 1'b0;
  logic        reset, run, step, mbus_ready, mem_req;
  logic        phf, phe, phm, phw, ph_done, halted, bus_err;
  logic [3:0]  wait_cnt;
  logic [31:0] icnt;
  logic [2:0]  clk_stat;

  typedef struct {
    int stat;
    int done;
    int hlt;
    int berr;
    int wcnt;
    int icnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  always #5 clk = ~clk;

  sched_ws #(.CNT_WIDTH(32), .WAIT_W(4), .WAIT_MAX(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .mbus_ready (mbus_ready),
    .mem_req    (mem_req),
    .phf        (phf),
    .phe        (phe),
    .phm        (phm),
    .phw        (phw),
    .ph_done    (ph_done),
    .halted     (halted),
    .bus_err    (bus_err),
    .wait_cnt   (wait_cnt),
    .icnt       (icnt),
    .clk_stat   (clk_stat)
  );

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL txn %0d %s: got %0d expected %0d", n_txn, name, act, req);
    end
  endtask

  // Monitor: compares the current cycle whenever an expectation is pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   ph_exp;
      e = exp_q.pop_front();
      case (e.stat)
        1, 5:    ph_exp = 4'b1000;
        2:       ph_exp = 4'b0100;
        3, 6:    ph_exp = 4'b0010;
        4:       ph_exp = 4'b0001;
        default: ph_exp = 4'b0000;
      endcase
      $display("txn %0d stat=%0d ph=%b done=%0d halted=%0d berr=%0d wcnt=%0d icnt=%0d",
               n_txn, clk_stat, {phf, phe, phm, phw}, ph_done, halted, bus_err,
               wait_cnt, icnt);
      chk("clk_stat", int'(clk_stat), e.stat);
      chk("phases", int'({phf, phe, phm, phw}), ph_exp);
      chk("ph_done", int'(ph_done), e.done);
      chk("halted", int'(halted), e.hlt);
      chk("bus_err", int'(bus_err), e.berr);
      chk("wait_cnt", int'(wait_cnt), e.wcnt);
      chk("icnt", int'(icnt), e.icnt);
      n_txn++;
    end
  end

  // Drive one cycle of inputs, queue its expected outputs, advance a cycle.
  task automatic sc(input logic r_n, input logic rn, input logic st,
                    input logic rdy, input logic mq,
                    input int stat, input int done, input int hlt,
                    input int berr, input int wcnt, input int ic);
    exp_t e;
    reset      = r_n;
    run        = rn;
    step       = st;
    mbus_ready = rdy;
    mem_req    = mq;
    e.stat = stat; e.done = done; e.hlt = hlt;
    e.berr = berr; e.wcnt = wcnt; e.icnt = ic;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; run = 1'b0; step = 1'b0; mbus_ready = 1'b0; mem_req = 1'b0;
    @(posedge clk);
    #1;
    sc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Free running, no waits: two full instructions.
    sc(1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      sc(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, k);
      sc(1, 1, 0, 1, 0, 2, 1, 0, 0, 0, k);
      sc(1, 1, 0, 1, 0, 3, 1, 0, 0, 0, k);
      sc(1, 1, 0, 1, 0, 4, 1, 0, 0, 0, k);
    end

    // Three fetch wait states.
    sc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    sc(1, 1, 0, 0, 0, 5, 0, 0, 0, 1, 2);
    sc(1, 1, 0, 0, 0, 5, 0, 0, 0, 2, 2);
    sc(1, 1, 0, 1, 0, 5, 1, 0, 0, 3, 2);
    sc(1, 1, 0, 0, 1, 2, 1, 0, 0, 0, 2);

    // Memory phase timeout: 16 cycles of M, bus_err on the last.
    for (int i = 0; i < 16; i++)
      sc(1, 1, 0, 0, 1, (i == 0) ? 3 : 6, (i == 15) ? 1 : 0, 0,
         (i == 15) ? 1 : 0, i, 2);
    sc(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 2);

    // Single step from HALT.
    sc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3);
    sc(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 3);
    sc(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 3);
    sc(1, 0, 0, 1, 0, 2, 1, 0, 0, 0, 3);
    sc(1, 0, 0, 1, 0, 3, 1, 0, 0, 0, 3);
    sc(1, 0, 0, 1, 0, 4, 1, 0, 0, 0, 3);
    sc(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 4);
    sc(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 4);

    // Run dropped during E: instruction still completes, then HALT.
    sc(1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 4);
    sc(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 4);
    sc(1, 0, 0, 1, 0, 2, 1, 0, 0, 0, 4);
    sc(1, 0, 0, 1, 0, 3, 1, 0, 0, 0, 4);
    sc(1, 0, 0, 1, 0, 4, 1, 0, 0, 0, 4);
    sc(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 5);

    // Step together with run behaves as run: continues after W.
    sc(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 5);
    sc(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 5);
    sc(1, 1, 0, 1, 0, 2, 1, 0, 0, 0, 5);
    sc(1, 1, 0, 1, 0, 3, 1, 0, 0, 0, 5);
    sc(1, 1, 0, 1, 0, 4, 1, 0, 0, 0, 5);
    sc(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 6);

    // Reset in the middle of an M wait.
    sc(1, 1, 0, 0, 1, 2, 1, 0, 0, 0, 6);
    sc(1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 6);
    sc(1, 1, 0, 0, 1, 6, 0, 0, 0, 1, 6);
    sc(1, 1, 0, 0, 1, 6, 0, 0, 0, 2, 6);
    sc(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    sc(1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    sc(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    sc(1, 1, 0, 1, 0, 2, 1, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("queue_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
